// File: rtl/cpu_run_ctrl_pkg.sv
// Shared encodings for the board run controller: run states, speed selects and the
// bit positions of the debounced button pulses and switch levels.
package cpu_run_ctrl_pkg;

  typedef enum logic [1:0] {
    StHalt = 2'b00,
    StRun  = 2'b01,
    StStep = 2'b10,
    StCrst = 2'b11
  } run_state_e;

  typedef enum logic [1:0] {
    SpeedFull  = 2'b00,
    SpeedFast  = 2'b01,
    SpeedMid   = 2'b10,
    SpeedSlow  = 2'b11
  } speed_e;

  localparam int unsigned BtnRun  = 0;
  localparam int unsigned BtnStep = 1;
  localparam int unsigned BtnPage = 2;
  localparam int unsigned BtnCrst = 4;

  localparam int unsigned SwSpeedLo   = 0;
  localparam int unsigned SwSpeedHi   = 1;
  localparam int unsigned SwAutoPause = 2;

endpackage

// File: rtl/cpu_run_ctrl_ce_tick_gen.sv
// Free-running speed divider; tick marks the cycles on which a running core may advance.
module ce_tick_gen
  import cpu_run_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W = 24
) (
  input  logic   clk,
  input  logic   rst,
  input  speed_e speed,
  output logic   tick
);

  logic [DIV_W-1:0] divider_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      divider_q <= '0;
    end else begin
      divider_q <= divider_q + DIV_W'(1);
    end
  end

  // Speed is decoded combinationally so a switch change affects the very next tick.
  always_comb begin
    tick = 1'b0;
    unique case (speed)
      SpeedFull: tick = 1'b1;
      SpeedFast: tick = (divider_q[9:0] == '0);
      SpeedMid:  tick = (divider_q[DIV_W/2-1:0] == '0);
      SpeedSlow: tick = (divider_q == '0);
      default:   tick = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for the OpenMIPS core: clock-enable generation, timed core reset,
// display-page select and executed-cycle counter.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W      = 24,
  parameter int unsigned RST_CYCLES = 16,
  parameter int unsigned NPAGES     = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  btn_pulse,
  input  logic [7:0]  sw_ok,
  output logic        cpu_ce,
  output logic        cpu_rst,
  output logic [1:0]  run_state,
  output logic [2:0]  disp_sel,
  output logic [15:0] ce_count
);

  localparam int unsigned RstCntW = $clog2(RST_CYCLES + 1);
  localparam logic [RstCntW-1:0] RstLoad = RstCntW'(RST_CYCLES - 1);

  run_state_e         state_q, state_d;
  logic [RstCntW-1:0] rst_cnt_q, rst_cnt_d;
  logic               cpu_rst_q, cpu_rst_d;
  logic               cpu_ce_q, cpu_ce_d;
  logic [2:0]         disp_sel_q, disp_sel_d;
  logic [15:0]        ce_count_q, ce_count_d;
  logic               tick;

  // STEP is only reachable from HALT, so the auto-pause switch never changes the outcome.
  logic unused_inputs;
  assign unused_inputs = ^{btn_pulse[3], sw_ok[7:SwAutoPause]};

  ce_tick_gen #(
    .DIV_W(DIV_W)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .speed(speed_e'(sw_ok[SwSpeedHi:SwSpeedLo])),
    .tick (tick)
  );

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    cpu_rst_d = cpu_rst_q;
    cpu_ce_d  = 1'b0;

    unique case (state_q)
      StCrst: begin
        if (btn_pulse[BtnCrst]) begin
          rst_cnt_d = RstLoad;
        end else if (rst_cnt_q == '0) begin
          state_d   = StHalt;
          cpu_rst_d = 1'b0;
        end else begin
          rst_cnt_d = rst_cnt_q - RstCntW'(1);
        end
      end
      StHalt: begin
        if (btn_pulse[BtnRun]) begin
          state_d = StRun;
        end else if (btn_pulse[BtnStep]) begin
          state_d = StStep;
        end
      end
      StRun: begin
        cpu_ce_d = tick;
        if (btn_pulse[BtnRun]) begin
          state_d = StHalt;
        end
      end
      StStep: begin
        cpu_ce_d = 1'b1;
        state_d  = StHalt;
      end
      default: state_d = StCrst;
    endcase

    // Core reset request overrides every other event and kills any pending enable.
    if (state_q != StCrst && btn_pulse[BtnCrst]) begin
      state_d   = StCrst;
      rst_cnt_d = RstLoad;
      cpu_rst_d = 1'b1;
      cpu_ce_d  = 1'b0;
    end

    ce_count_d = (state_d == StCrst) ? '0 : ce_count_q + 16'(cpu_ce_q);

    disp_sel_d = disp_sel_q;
    if (btn_pulse[BtnPage]) begin
      disp_sel_d = (disp_sel_q == 3'(NPAGES - 1)) ? '0 : disp_sel_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StCrst;
      rst_cnt_q  <= RstLoad;
      cpu_rst_q  <= 1'b1;
      cpu_ce_q   <= 1'b0;
      disp_sel_q <= '0;
      ce_count_q <= '0;
    end else begin
      state_q    <= state_d;
      rst_cnt_q  <= rst_cnt_d;
      cpu_rst_q  <= cpu_rst_d;
      cpu_ce_q   <= cpu_ce_d;
      disp_sel_q <= disp_sel_d;
      ce_count_q <= ce_count_d;
    end
  end

  assign cpu_ce    = cpu_ce_q;
  assign cpu_rst   = cpu_rst_q;
  assign run_state = state_q;
  assign disp_sel  = disp_sel_q;
  assign ce_count  = ce_count_q;

endmodule
